trng_ehr_accum_ctrl: RTL and testbench
======================================

TRNG_EHR_ACCUM_CTRL -- requirements
Module: trng_ehr_accum_ctrl

Interface
REQ-001 Parameter EHR_WIDTH, default 192: bits per EHR slot; SHALL be a multiple of both SAMPLE_W and WORD_W.
REQ-002 Parameter SAMPLE_W, default 16: bits added per accepted sample.
REQ-003 Parameter WORD_W, default 32: bits removed per CPU word read.
REQ-004 Parameter NUM_SLOTS, default 2: EHR slots; power of two, ≥1. CNT_W=clog2(EHR_WIDTH+1), SLOT_W=max(1,clog2(NUM_SLOTS)).
REQ-005 rng_clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rst_trng_logic  in  1  synchronous clear of all state.
REQ-008 crngt_valid  in  1  CRNGT-checked sample available.
REQ-009 collector_valid  in  1  raw collector sample available.
REQ-010 crngt_bypass  in  1  accept raw collector samples.
REQ-011 test_err  in  1  health-test failure on current fill slot.
REQ-012 autocorr_done / autocorr_bypass  in  1 each  autocorrelation finished / skipped for fill slot.
REQ-013 word_rd  in  1  CPU reads one WORD_W word from head slot.
REQ-014 prng_rd  in  1  PRNG consumes whole head slot.
REQ-015 cpu_mid_rd  in  1  CPU mid-read outside debug mode; gates prng_ehr_valid.
REQ-016 fill_bits  out  CNT_W  bits accumulated in fill slot.
REQ-017 head_valid / prng_ehr_valid  out  1 each  head slot sealed / head_valid & !cpu_mid_rd.
REQ-018 head_bits  out  CNT_W  unread bits in head slot.
REQ-019 occupancy  out  SLOT_W+1  sealed slots; full out 1 = (occupancy==NUM_SLOTS).
REQ-020 overflow / rd_underflow  out  1 each  single-cycle pulses; err_drop_cnt  out  8  saturating count of discarded fills.

Function
REQ-021 Sample accepted when (crngt_valid | (crngt_bypass & collector_valid)) and fill state FILLING; else dropped, overflow pulses if cause is full.
REQ-022 Fill FSM: FILLING -> WAIT_TEST when fill_bits reaches EHR_WIDTH; WAIT_TEST -> SEAL when (autocorr_done|autocorr_bypass) & !test_err; SEAL -> FILLING next slot if !full after seal, else STALL; STALL -> FILLING when a slot frees.
REQ-023 test_err in FILLING or WAIT_TEST: fill_bits <= 0, state FILLING, err_drop_cnt +1 (saturates at 255); test_err overrides a same-cycle sample.
REQ-024 Accepted sample at edge N reflected in fill_bits at N+1; seal at edge N gives head_valid/occupancy update at N+1.
REQ-025 Slots sealed and consumed in FIFO order; head/tail pointers wrap modulo NUM_SLOTS.
REQ-026 word_rd with head_valid: head_bits -= WORD_W; reaching 0 frees slot, head advances, occupancy -1.
REQ-027 prng_rd with head_valid frees head slot immediately regardless of head_bits; prng_rd wins over same-cycle word_rd.
REQ-028 word_rd or prng_rd with !head_valid: no state change, rd_underflow pulses.
REQ-029 Same-cycle seal and free: both take effect; occupancy unchanged; full never glitches.
REQ-030 NUM_SLOTS=1 SHALL reproduce single-EHR behaviour: no new fill until slot read out.

Reset
REQ-031 rst or rst_trng_logic: fill_bits=0, head_bits=0, pointers=0, occupancy=0, err_drop_cnt=0, FSM FILLING, all valid/pulse outputs 0; reset mid-fill discards partial data.

Structure
REQ-032 Fill-state encoding and default widths live in shared package trng_pkg.
REQ-033 One sub-module trng_ehr_slot_fifo holds per-slot head_bits, pointers and occupancy; the top holds fill FSM and sample arithmetic.

Verification (defaults)
REQ-034 12 crngt_valid pulses, autocorr_bypass=1 -> fill_bits 192, head_valid next cycle, occupancy 1.
REQ-035 6 word_rd on sealed head -> head_bits 160..0, slot freed after 6th, occupancy 0, head_valid 0.
REQ-036 test_err after 11th sample -> fill_bits 0, err_drop_cnt 1, no seal.
REQ-037 Fill both slots, one more sample -> overflow 1 cycle, fill_bits 0, STALL until prng_rd frees slot.
REQ-038 prng_rd+word_rd same cycle with head_bits 192 -> slot freed, no underflow; word_rd when empty -> rd_underflow.
REQ-039 rst asserted at fill_bits 96 -> all outputs 0 same cycle, refill from 0 after release.

Source files
------------

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared fill-state encoding and default widths for the EHR accumulator
package trng_pkg;

  localparam int DEF_EHR_WIDTH = 192;
  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_SLOTS = 2;
  localparam int DEF_CNT_W     = $clog2(DEF_EHR_WIDTH + 1);
  localparam int DEF_SLOT_W    = (DEF_NUM_SLOTS > 1) ? $clog2(DEF_NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    FILL_FILLING   = 2'd0,
    FILL_WAIT_TEST = 2'd1,
    FILL_SEAL      = 2'd2,
    FILL_STALL     = 2'd3
  } fill_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trng_ehr_accum_ctrl_if.sv
// rtl/trng_ehr_accum_ctrl_if.sv - sample, health-test, read and status signals of the EHR accumulator
interface trng_ehr_accum_ctrl_if #(
  parameter int CNT_W  = trng_pkg::DEF_CNT_W,
  parameter int SLOT_W = trng_pkg::DEF_SLOT_W
);
  logic              rst_trng_logic;
  logic              crngt_valid;
  logic              collector_valid;
  logic              crngt_bypass;
  logic              test_err;
  logic              autocorr_done;
  logic              autocorr_bypass;
  logic              word_rd;
  logic              prng_rd;
  logic              cpu_mid_rd;
  logic [CNT_W-1:0]  fill_bits;
  logic              head_valid;
  logic              prng_ehr_valid;
  logic [CNT_W-1:0]  head_bits;
  logic [SLOT_W:0]   occupancy;
  logic              full;
  logic              overflow;
  logic              rd_underflow;
  logic [7:0]        err_drop_cnt;

  modport master (
    output rst_trng_logic, crngt_valid, collector_valid, crngt_bypass, test_err,
           autocorr_done, autocorr_bypass, word_rd, prng_rd, cpu_mid_rd,
    input  fill_bits, head_valid, prng_ehr_valid, head_bits, occupancy, full,
           overflow, rd_underflow, err_drop_cnt
  );

  modport slave (
    input  rst_trng_logic, crngt_valid, collector_valid, crngt_bypass, test_err,
           autocorr_done, autocorr_bypass, word_rd, prng_rd, cpu_mid_rd,
    output fill_bits, head_valid, prng_ehr_valid, head_bits, occupancy, full,
           overflow, rd_underflow, err_drop_cnt
  );
endinterface

// File: rtl/trng_ehr_slot_fifo.sv
// rtl/trng_ehr_slot_fifo.sv - sealed EHR slots in FIFO order with per-slot unread bit counts
module trng_ehr_slot_fifo #(
  parameter int EHR_WIDTH = 192,
  parameter int WORD_W    = 32,
  parameter int NUM_SLOTS = 2,
  parameter int CNT_W     = 8,
  parameter int SLOT_W    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              word_rd_i,
  input  logic              prng_rd_i,
  output logic              head_valid_o,
  output logic [CNT_W-1:0]  head_bits_o,
  output logic [SLOT_W:0]   occupancy_o,
  output logic              full_o,
  output logic              free_o,
  output logic              rd_underflow_o
);

  logic [CNT_W-1:0]  bits_q [NUM_SLOTS];
  logic [SLOT_W-1:0] rd_ptr_q;
  logic [SLOT_W-1:0] wr_ptr_q;
  logic [SLOT_W:0]   occ_q;
  logic [SLOT_W:0]   occ_d;
  logic              unf_q;
  logic              head_valid;
  logic              last_word;
  logic              word_dec;
  logic              free;

  function automatic logic [SLOT_W-1:0] nxt_ptr(input logic [SLOT_W-1:0] p);
    return (p == SLOT_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (occ_q != '0);
  assign last_word  = (bits_q[rd_ptr_q] == CNT_W'(WORD_W));
  // prng_rd takes the whole slot, so a same-cycle word_rd must not also decrement it
  assign word_dec   = head_valid & word_rd_i & ~prng_rd_i;
  assign free       = head_valid & (prng_rd_i | (word_rd_i & last_word));
  assign occ_d      = occ_q + (SLOT_W + 1)'(push_i) - (SLOT_W + 1)'(free);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) bits_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      unf_q    <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) bits_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      unf_q    <= 1'b0;
    end else begin
      unf_q <= (word_rd_i | prng_rd_i) & ~head_valid;
      occ_q <= occ_d;
      if (push_i) begin
        bits_q[wr_ptr_q] <= CNT_W'(EHR_WIDTH);
        wr_ptr_q         <= nxt_ptr(wr_ptr_q);
      end
      if (word_dec) begin
        bits_q[rd_ptr_q] <= bits_q[rd_ptr_q] - CNT_W'(WORD_W);
      end
      if (free) begin
        rd_ptr_q <= nxt_ptr(rd_ptr_q);
      end
    end
  end

  assign head_valid_o   = head_valid;
  assign head_bits_o    = head_valid ? bits_q[rd_ptr_q] : '0;
  assign occupancy_o    = occ_q;
  assign full_o         = (occ_q == (SLOT_W + 1)'(NUM_SLOTS));
  assign free_o         = free;
  assign rd_underflow_o = unf_q;

endmodule

// File: rtl/trng_ehr_accum_ctrl.sv
// rtl/trng_ehr_accum_ctrl.sv - EHR fill FSM and sample accumulation feeding a FIFO of sealed slots
module trng_ehr_accum_ctrl
  import trng_pkg::*;
#(
  parameter int EHR_WIDTH = DEF_EHR_WIDTH,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
  input logic                  rng_clk,
  input logic                  rst,
  trng_ehr_accum_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(EHR_WIDTH + 1);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  fill_state_e      state_q;
  fill_state_e      state_d;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic [7:0]       err_q;
  logic [7:0]       err_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             sample_v;
  logic             seal;
  logic             full;
  logic             free;
  logic             head_valid;

  assign sample_v = bus.crngt_valid | (bus.crngt_bypass & bus.collector_valid);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    err_d   = err_q;
    ovf_d   = 1'b0;
    seal    = 1'b0;
    case (state_q)
      FILL_FILLING: begin
        if (bus.test_err) begin
          fill_d = '0;
          err_d  = sat_inc8(err_q);
        end else if (sample_v) begin
          fill_d = fill_q + CNT_W'(SAMPLE_W);
          if (fill_d == CNT_W'(EHR_WIDTH)) state_d = FILL_WAIT_TEST;
        end
      end
      FILL_WAIT_TEST: begin
        if (bus.test_err) begin
          fill_d  = '0;
          err_d   = sat_inc8(err_q);
          state_d = FILL_FILLING;
        end else if (bus.autocorr_done | bus.autocorr_bypass) begin
          // Slot contents move into the FIFO; the fill counter restarts immediately
          seal    = 1'b1;
          fill_d  = '0;
          state_d = FILL_SEAL;
        end
      end
      FILL_SEAL: begin
        state_d = (full && !free) ? FILL_STALL : FILL_FILLING;
      end
      FILL_STALL: begin
        ovf_d = sample_v;
        if (!full || free) state_d = FILL_FILLING;
      end
      default: state_d = FILL_FILLING;
    endcase
  end

  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL_FILLING;
      fill_q  <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.rst_trng_logic) begin
      state_q <= FILL_FILLING;
      fill_q  <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  trng_ehr_slot_fifo #(
    .EHR_WIDTH (EHR_WIDTH),
    .WORD_W    (WORD_W),
    .NUM_SLOTS (NUM_SLOTS),
    .CNT_W     (CNT_W),
    .SLOT_W    (SLOT_W)
  ) u_slot_fifo (
    .clk_i          (rng_clk),
    .rst_i          (rst),
    .clr_i          (bus.rst_trng_logic),
    .push_i         (seal),
    .word_rd_i      (bus.word_rd),
    .prng_rd_i      (bus.prng_rd),
    .head_valid_o   (head_valid),
    .head_bits_o    (bus.head_bits),
    .occupancy_o    (bus.occupancy),
    .full_o         (full),
    .free_o         (free),
    .rd_underflow_o (bus.rd_underflow)
  );

  assign bus.fill_bits      = fill_q;
  assign bus.head_valid     = head_valid;
  assign bus.prng_ehr_valid = head_valid & ~bus.cpu_mid_rd;
  assign bus.full           = full;
  assign bus.overflow       = ovf_q;
  assign bus.err_drop_cnt   = err_q;

endmodule

// File: tb/tb_trng_ehr_accum_ctrl.sv
// tb/tb_trng_ehr_accum_ctrl.sv - scoreboard bench for the EHR accumulator controller
module tb_trng_ehr_accum_ctrl;

  typedef enum int {O_FILL, O_HV, O_PV, O_HB, O_OCC, O_FULL, O_OVF, O_UNF, O_ERR} obs_e;
  typedef struct {
    obs_e sel;
    int   val;
  } sb_item_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  int       n_total = 0;
  int       n_bad = 0;
  sb_item_t sb[$];

  trng_ehr_accum_ctrl_if ifc();

  trng_ehr_accum_ctrl dut (
    .rng_clk (clk),
    .rst     (rst),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int observe(obs_e s);
    case (s)
      O_FILL:  return int'(ifc.fill_bits);
      O_HV:    return int'(ifc.head_valid);
      O_PV:    return int'(ifc.prng_ehr_valid);
      O_HB:    return int'(ifc.head_bits);
      O_OCC:   return int'(ifc.occupancy);
      O_FULL:  return int'(ifc.full);
      O_OVF:   return int'(ifc.overflow);
      O_UNF:   return int'(ifc.rd_underflow);
      default: return int'(ifc.err_drop_cnt);
    endcase
  endfunction

  task automatic expect_o(input obs_e s, input int v);
    sb_item_t it;
    it.sel = s;
    it.val = v;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      chk(it.sel.name(), observe(it.sel), it.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic expect_all_zero();
    expect_o(O_FILL, 0); expect_o(O_HV, 0); expect_o(O_PV, 0); expect_o(O_HB, 0);
    expect_o(O_OCC, 0);  expect_o(O_FULL, 0); expect_o(O_OVF, 0); expect_o(O_UNF, 0);
    expect_o(O_ERR, 0);
  endtask

  // Feeds n samples on crngt_valid, expecting the fill count to climb from 'start'
  task automatic feed(input int n, input int start);
    for (int i = 1; i <= n; i++) begin
      ifc.crngt_valid = 1'b1;
      expect_o(O_FILL, start + 16 * i);
      step();
    end
    ifc.crngt_valid = 1'b0;
  endtask

  initial begin
    ifc.rst_trng_logic  = 1'b0;
    ifc.crngt_valid     = 1'b0;
    ifc.collector_valid = 1'b0;
    ifc.crngt_bypass    = 1'b0;
    ifc.test_err        = 1'b0;
    ifc.autocorr_done   = 1'b0;
    ifc.autocorr_bypass = 1'b0;
    ifc.word_rd         = 1'b0;
    ifc.prng_rd         = 1'b0;
    ifc.cpu_mid_rd      = 1'b0;

    expect_all_zero();
    step();
    step();
    rst = 1'b0;

    // Fill one slot with bypassed autocorrelation, then seal
    ifc.autocorr_bypass = 1'b1;
    feed(11, 0);
    expect_o(O_HV, 0);
    feed(1, 176);
    expect_o(O_HV, 1); expect_o(O_OCC, 1); expect_o(O_FILL, 0); expect_o(O_HB, 192);
    expect_o(O_FULL, 0); expect_o(O_PV, 1);
    step();
    step();

    // Drain the head slot one word at a time
    for (int i = 1; i <= 6; i++) begin
      ifc.word_rd = 1'b1;
      expect_o(O_HB, 192 - 32 * i);
      expect_o(O_UNF, 0);
      if (i == 6) begin
        expect_o(O_HV, 0);
        expect_o(O_OCC, 0);
      end else begin
        expect_o(O_OCC, 1);
      end
      step();
    end
    ifc.word_rd = 1'b0;

    // Raw collector samples count only with crngt_bypass
    ifc.collector_valid = 1'b1;
    expect_o(O_FILL, 0);
    step();
    ifc.crngt_bypass = 1'b1;
    expect_o(O_FILL, 16);
    step();
    ifc.collector_valid = 1'b0;
    ifc.crngt_bypass    = 1'b0;
    feed(10, 16);

    // Health-test failure after the 11th sample discards the fill
    ifc.test_err = 1'b1;
    expect_o(O_FILL, 0); expect_o(O_ERR, 1); expect_o(O_HV, 0);
    step();
    ifc.test_err = 1'b0;
    expect_o(O_HV, 0); expect_o(O_OCC, 0);
    step();

    // test_err wins over a same-cycle sample
    feed(3, 0);
    ifc.test_err    = 1'b1;
    ifc.crngt_valid = 1'b1;
    expect_o(O_FILL, 0); expect_o(O_ERR, 2);
    step();
    ifc.test_err    = 1'b0;
    ifc.crngt_valid = 1'b0;

    // test_err while waiting on the autocorrelation test
    ifc.autocorr_bypass = 1'b0;
    feed(12, 0);
    step();
    expect_o(O_HV, 0);
    ifc.test_err = 1'b1;
    expect_o(O_FILL, 0); expect_o(O_ERR, 3); expect_o(O_HV, 0);
    step();

    // Saturation of the drop counter
    for (int i = 0; i < 252; i++) begin
      if (i == 251) expect_o(O_ERR, 255);
      step();
    end
    expect_o(O_ERR, 255);
    step();
    ifc.test_err = 1'b0;
    step();

    // Fill both slots, then overflow while stalled
    feed(12, 0);
    ifc.autocorr_done = 1'b1;
    expect_o(O_OCC, 1); expect_o(O_HV, 1); expect_o(O_FILL, 0);
    step();
    ifc.autocorr_done = 1'b0;
    step();
    feed(12, 0);
    ifc.autocorr_done = 1'b1;
    expect_o(O_OCC, 2); expect_o(O_FULL, 1);
    step();
    ifc.autocorr_done = 1'b0;
    expect_o(O_FULL, 1);
    step();
    ifc.crngt_valid = 1'b1;
    expect_o(O_OVF, 1); expect_o(O_FILL, 0);
    step();
    ifc.crngt_valid = 1'b0;
    expect_o(O_OVF, 0); expect_o(O_FILL, 0); expect_o(O_OCC, 2);
    step();
    ifc.prng_rd = 1'b1;
    expect_o(O_OCC, 1); expect_o(O_FULL, 0); expect_o(O_HB, 192); expect_o(O_UNF, 0);
    step();
    ifc.prng_rd = 1'b0;
    feed(1, 0);

    // prng_rd beats a same-cycle word_rd; then a read when empty underflows
    ifc.prng_rd = 1'b1;
    ifc.word_rd = 1'b1;
    expect_o(O_OCC, 0); expect_o(O_HV, 0); expect_o(O_UNF, 0); expect_o(O_HB, 0);
    step();
    ifc.prng_rd = 1'b0;
    expect_o(O_UNF, 1); expect_o(O_OCC, 0);
    step();
    ifc.word_rd = 1'b0;
    expect_o(O_UNF, 0);
    step();

    // Wrapped slot index, cpu_mid_rd gating and a word read after wrap
    feed(11, 16);
    ifc.autocorr_bypass = 1'b1;
    expect_o(O_HV, 1); expect_o(O_PV, 1); expect_o(O_OCC, 1); expect_o(O_HB, 192);
    step();
    ifc.cpu_mid_rd = 1'b1;
    expect_o(O_PV, 0); expect_o(O_HV, 1);
    step();
    ifc.cpu_mid_rd = 1'b0;
    ifc.word_rd    = 1'b1;
    expect_o(O_HB, 160); expect_o(O_PV, 1);
    step();
    ifc.word_rd = 1'b0;

    // Synchronous clear
    feed(2, 0);
    ifc.rst_trng_logic = 1'b1;
    expect_all_zero();
    step();
    ifc.rst_trng_logic = 1'b0;

    // Asynchronous reset mid-fill
    feed(6, 0);
    #2;
    rst = 1'b1;
    #1;
    expect_all_zero();
    drain();
    ifc.crngt_valid = 1'b1;
    expect_o(O_FILL, 0);
    step();
    rst = 1'b0;
    expect_o(O_FILL, 16);
    step();
    ifc.crngt_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
